aes_spi_frame_port: RTL and testbench

Serial front end that sits directly upstream of the AES encryption core. It deserialises a host frame (cipher key followed by one 128-bit plaintext block) from a one-bit serial line, presents both words in parallel to the core with a `ready` level, then captures the core's ciphertext and serialises it back to the host. All transfers are one bit per `clk` cycle, MSB first, gated by `cs`.

---
 rtl/aes_spi_frame_port.sv | 101 ++++++++++
 tb/tb_aes_spi_frame_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_frame_port.sv
// Serial front end for the AES core: deserialises key+plaintext MSB first, holds them with ready,
// then serialises the core's ciphertext back out. One bit per clk while cs is high.
module aes_spi_frame_port #(
  parameter int Nk = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cs,
  input  logic                 i_miso,
  output logic                 o_mosi,
  output logic [Nk*32-1:0]     o_key,
  output logic [127:0]         o_in_block,
  output logic                 o_ready,
  input  logic [127:0]         i_result,
  input  logic                 i_result_valid
);

  localparam int KEY_W = Nk * 32;
  localparam int FR_W  = KEY_W + 128;
  localparam logic [8:0] LAST_CNT = 9'(KEY_W + 127);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_WAIT,
    S_TX
  } state_t;

  state_t            r_state;
  // The final frame bit goes straight from miso into the commit, so it is never stored.
  logic [FR_W-2:0]   r_rx_sr;
  logic [127:0]      r_tx_sr;
  logic [8:0]        r_bit_cnt;
  logic [KEY_W-1:0]  r_key;
  logic [127:0]      r_blk;
  logic              r_ready;
  logic [FR_W-1:0]   w_rx_next;

  assign w_rx_next  = {r_rx_sr, i_miso};
  assign o_mosi     = (r_state == S_TX) ? r_tx_sr[127] : 1'b0;
  assign o_key      = r_key;
  assign o_in_block = r_blk;
  assign o_ready    = r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rx_sr   <= '0;
      r_tx_sr   <= '0;
      r_bit_cnt <= '0;
      r_key     <= '0;
      r_blk     <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cs) begin
            r_rx_sr   <= w_rx_next[FR_W-2:0];
            r_bit_cnt <= 9'd1;
            r_state   <= S_RX;
          end
        end
        S_RX: begin
          if (!i_cs) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_rx_sr   <= w_rx_next[FR_W-2:0];
            r_bit_cnt <= r_bit_cnt + 9'd1;
            if (r_bit_cnt == LAST_CNT) begin
              r_key   <= w_rx_next[FR_W-1 -: KEY_W];
              r_blk   <= w_rx_next[127:0];
              r_ready <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_result_valid) begin
            r_tx_sr   <= i_result;
            r_bit_cnt <= '0;
            r_ready   <= 1'b0;
            r_state   <= S_TX;
          end
        end
        S_TX: begin
          if (i_cs) begin
            r_tx_sr   <= {r_tx_sr[126:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 9'd1;
            if (r_bit_cnt == 9'd127) begin
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_frame_port.sv
// Bench for aes_spi_frame_port: three instances (Nk=4,6,8) checked every cycle against a
// frame-level model, plus literal FIPS-197 vectors that pin the model.
module tb_aes_spi_frame_port;

  localparam int P_IDLE = 0;
  localparam int P_RX   = 1;
  localparam int P_WAIT = 2;
  localparam int P_TX   = 3;

  logic         clk;
  logic         rst;
  logic [2:0]   cs;
  logic [2:0]   miso;
  logic [2:0]   rv;
  logic [127:0] res [3];
  logic [2:0]   w_mosi;
  logic [2:0]   w_ready;
  logic [127:0] w_blk [3];
  logic [127:0] w_key4;
  logic [191:0] w_key6;
  logic [255:0] w_key8;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // model state, index 0:Nk=4, 1:Nk=6, 2:Nk=8
  int           ph [3];
  int           n [3];
  int           tpos [3];
  logic [383:0] fr [3];
  logic [255:0] mkey [3];
  logic [127:0] mblk [3];
  logic [127:0] mres [3];

  aes_spi_frame_port #(.Nk(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_cs(cs[0]), .i_miso(miso[0]), .o_mosi(w_mosi[0]),
    .o_key(w_key4), .o_in_block(w_blk[0]), .o_ready(w_ready[0]),
    .i_result(res[0]), .i_result_valid(rv[0]));
  aes_spi_frame_port #(.Nk(6)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_cs(cs[1]), .i_miso(miso[1]), .o_mosi(w_mosi[1]),
    .o_key(w_key6), .o_in_block(w_blk[1]), .o_ready(w_ready[1]),
    .i_result(res[1]), .i_result_valid(rv[1]));
  aes_spi_frame_port #(.Nk(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_cs(cs[2]), .i_miso(miso[2]), .o_mosi(w_mosi[2]),
    .o_key(w_key8), .o_in_block(w_blk[2]), .o_ready(w_ready[2]),
    .i_result(res[2]), .i_result_valid(rv[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kw_of(input int m);
    return (4 + 2 * m) * 32;
  endfunction

  function automatic logic [255:0] dkey(input int m);
    if (m == 0) return {128'd0, w_key4};
    if (m == 1) return {64'd0, w_key6};
    return w_key8;
  endfunction

  // frame bit i (in arrival order) is stored at fr[i]
  function automatic logic [383:0] f_set(input logic [383:0] f, input int idx, input logic b);
    logic [383:0] t;
    t = f;
    t[idx] = b;
    return t;
  endfunction

  function automatic logic [255:0] f_key(input logic [383:0] f, input int kw);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < kw; i++) k[kw-1-i] = f[i];
    return k;
  endfunction

  function automatic logic [127:0] f_blk(input logic [383:0] f, input int kw);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 128; i++) b[127-i] = f[kw+i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 3; m++) begin
        ph[m] <= P_IDLE; n[m] <= 0; tpos[m] <= 0; mkey[m] <= '0; mblk[m] <= '0;
      end
    end else begin
      for (int m = 0; m < 3; m++) begin
        case (ph[m])
          P_IDLE: if (cs[m]) begin
            fr[m][0] <= miso[m]; n[m] <= 1; ph[m] <= P_RX;
          end
          P_RX: if (!cs[m]) begin
            ph[m] <= P_IDLE; n[m] <= 0;
          end else begin
            fr[m][n[m]] <= miso[m];
            n[m] <= n[m] + 1;
            if (n[m] == kw_of(m) + 127) begin
              mkey[m] <= f_key(f_set(fr[m], n[m], miso[m]), kw_of(m));
              mblk[m] <= f_blk(f_set(fr[m], n[m], miso[m]), kw_of(m));
              ph[m]   <= P_WAIT;
            end
          end
          P_WAIT: if (rv[m]) begin
            mres[m] <= res[m]; tpos[m] <= 0; ph[m] <= P_TX;
          end
          default: if (cs[m]) begin
            tpos[m] <= tpos[m] + 1;
            if (tpos[m] == 127) ph[m] <= P_IDLE;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("mosi%0d", m), 256'(w_mosi[m]),
            256'((ph[m] == P_TX) ? mres[m][127-tpos[m]] : 1'b0));
        chk($sformatf("ready%0d", m), 256'(w_ready[m]), 256'(ph[m] == P_WAIT));
        chk($sformatf("key%0d", m), dkey(m), mkey[m]);
        chk($sformatf("blk%0d", m), 256'(w_blk[m]), 256'(mblk[m]));
      end
    end
  end

  task automatic send_frame(input int m, input logic [383:0] f, input int len,
                            input int nbits, input int rv_at);
    for (int i = 0; i < nbits; i++) begin
      cs[m]   = 1'b1;
      miso[m] = f[len-1-i];
      rv[m]   = (i == rv_at);
      tick();
      if (nbits == len && i == len - 2) chk("rdy_early", 256'(w_ready[m]), 256'd0);
    end
    rv[m] = 1'b0;
    if (nbits == len) chk("rdy_latency", 256'(w_ready[m]), 256'd1);
  endtask

  task automatic pulse_rv(input int m, input logic [127:0] r);
    res[m] = r;
    rv[m]  = 1'b1;
    tick();
    rv[m]  = 1'b0;
  endtask

  task automatic tx_run(input int m, input int nb, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < nb; i++) begin
      got[127-i] = w_mosi[m];
      cs[m] = 1'b1;
      tick();
    end
  endtask

  task automatic chk_zero(input int m);
    chk("rst_mosi", 256'(w_mosi[m]), 256'd0);
    chk("rst_ready", 256'(w_ready[m]), 256'd0);
    chk("rst_key", dkey(m), 256'd0);
    chk("rst_blk", 256'(w_blk[m]), 256'd0);
  endtask

  initial begin
    logic [127:0] ct;
    logic [127:0] got;
    logic [383:0] f1;
    logic [383:0] f2;
    rst = 1'b1; cs = '0; miso = '0; rv = '0;
    for (int m = 0; m < 3; m++) res[m] = '0;
    tick();
    started = 1'b1;
    tick();
    for (int m = 0; m < 3; m++) chk_zero(m);
    rst = 1'b0;
    tick();

    // Nk=4: result_valid in IDLE ignored
    pulse_rv(0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    tick();
    chk("idle_rv_mosi", 256'(w_mosi[0]), 256'd0);
    chk("idle_rv_ready", 256'(w_ready[0]), 256'd0);

    // Nk=4 FIPS-197 frame, result_valid pulsed mid-RX
    send_frame(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff},
               256, 256, 100);
    chk("fips_key", dkey(0), 256'h000102030405060708090a0b0c0d0e0f);
    chk("fips_blk", 256'(w_blk[0]), 256'h00112233445566778899aabbccddeeff);
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pulse_rv(0, ct);
    chk("rdy_fall", 256'(w_ready[0]), 256'd0);
    got = '0;
    for (int i = 0; i < 128; i++) begin
      if (i == 64) begin
        cs[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("tx_hold", 256'(w_mosi[0]), 256'(ct[63]));
        end
      end
      got[127-i] = w_mosi[0];
      cs[0] = 1'b1;
      tick();
    end
    cs[0] = 1'b0;
    chk("fips_ct", 256'(got), 256'(ct));
    tick();
    chk("idle_mosi", 256'(w_mosi[0]), 256'd0);

    // Nk=8: full frame, back-to-back partial frame aborted after 200 bits
    f1 = {256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
          128'h6bc1bee22e409f96e93d7e117393172a};
    f2 = ~f1;
    send_frame(2, f1, 384, 384, -1);
    chk("k8_key", dkey(2), 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    chk("k8_blk", 256'(w_blk[2]), 256'h6bc1bee22e409f96e93d7e117393172a);
    pulse_rv(2, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8);
    tx_run(2, 128, got);
    chk("k8_ct", 256'(got), 256'hf3eed1bdb5d2a03c064b5a7e3db181f8);
    send_frame(2, f2, 384, 200, -1);
    cs[2] = 1'b0;
    tick();
    chk("abort_ready", 256'(w_ready[2]), 256'd0);
    chk("abort_key", dkey(2), 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    chk("abort_blk", 256'(w_blk[2]), 256'h6bc1bee22e409f96e93d7e117393172a);

    // Nk=6: async reset mid-TX and mid-RX, then a clean frame
    send_frame(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                   128'h6bc1bee22e409f96e93d7e117393172a}, 320, 320, -1);
    chk("k6a_key", dkey(1), 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
    pulse_rv(1, {128{1'b1}});
    tx_run(1, 60, got);
    chk("pre_rst_mosi", 256'(w_mosi[1]), 256'd1);
    #2 rst = 1'b1;
    #1 chk_zero(1);
    cs[1] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    f2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
          128'h00112233445566778899aabbccddeeff};
    send_frame(1, f2, 320, 150, -1);
    #2 rst = 1'b1;
    #1 chk_zero(1);
    cs[1] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_frame(1, f2, 320, 320, -1);
    cs[1] = 1'b0;
    chk("k6b_key", dkey(1), 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
    chk("k6b_blk", 256'(w_blk[1]), 256'h00112233445566778899aabbccddeeff);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
